// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - radix-2 iterative RV32M multiply/divide sequencer
// Define MDU_DIV_EN to build the divider datapath; without it DIV/REM ops finish at once with err=1.
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        stall,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic        neg_q;
    logic        fast_q;
    logic        fast_err_q;
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [31:0] mag_b_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] result_q;
`ifdef MDU_DIV_EN
    logic        div_q;
    logic        rneg_q;
`endif

    logic        signed_a, signed_b, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;

    // MUL only keeps the low word, so treating it as signed*signed is harmless.
    assign signed_a = !(funct3[0] && (funct3[1] || funct3[2]));
    assign signed_b = funct3[2] ? !funct3[0] : !funct3[1];
    assign neg_a    = signed_a && op_a[31];
    assign neg_b    = signed_b && op_b[31];
    assign mag_a    = neg_a ? -op_a : op_a;
    assign mag_b    = neg_b ? -op_b : op_b;

    logic        fast;
    logic        fast_err;
    logic [31:0] fast_res;

    always_comb begin
        fast     = 1'b0;
        fast_err = 1'b0;
        fast_res = '0;
`ifdef MDU_DIV_EN
        if (funct3[2]) begin
            if (op_b == 32'h0) begin
                fast     = 1'b1;
                fast_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
            end else if (!funct3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                fast     = 1'b1;
                fast_res = funct3[1] ? 32'h0 : 32'h8000_0000;
            end
        end
`else
        if (funct3[2]) begin
            fast     = 1'b1;
            fast_err = 1'b1;
        end
`endif
    end

    // Both datapaths start from {hi=0, lo=|a|}: multiply shifts right, divide shifts left.
    logic [32:0] mul_sum;
    logic [31:0] acc_hi_d;
    logic [31:0] acc_lo_d;

    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);

`ifdef MDU_DIV_EN
    logic [32:0] trial;
    logic        ge;
    assign trial = {acc_hi_q, acc_lo_q[31]} - {1'b0, mag_b_q};
    assign ge    = !trial[32];
`endif

    always_comb begin
        acc_hi_d = mul_sum[32:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
`ifdef MDU_DIV_EN
        if (div_q) begin
            acc_hi_d = ge ? trial[31:0] : {acc_hi_q[30:0], acc_lo_q[31]};
            acc_lo_d = {acc_lo_q[30:0], ge};
        end
`endif
    end

    logic [63:0] prod_s;
    logic [31:0] final_res;

    assign prod_s = neg_q ? -{acc_hi_d, acc_lo_d} : {acc_hi_d, acc_lo_d};

    always_comb begin
        final_res = (op_q == 2'b00) ? prod_s[31:0] : prod_s[63:32];
`ifdef MDU_DIV_EN
        if (div_q) begin
            if (op_q[1])
                final_res = rneg_q ? -acc_hi_d : acc_hi_d;
            else
                final_res = neg_q ? -acc_lo_d : acc_lo_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            fast_q     <= 1'b0;
            fast_err_q <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            mag_b_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
`ifdef MDU_DIV_EN
            div_q      <= 1'b0;
            rneg_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        state_q    <= S_BUSY;
                        busy_q     <= 1'b1;
                        op_q       <= funct3[1:0];
                        neg_q      <= neg_a ^ neg_b;
                        fast_q     <= fast;
                        fast_err_q <= fast_err;
                        acc_hi_q   <= '0;
                        mag_b_q    <= mag_b;
`ifdef MDU_DIV_EN
                        div_q      <= funct3[2];
                        rneg_q     <= neg_a;
`endif
                        // Special cases park their answer in acc_lo and finish on the next edge.
                        if (fast) begin
                            cnt_q    <= 5'd31;
                            acc_lo_q <= fast_res;
                        end else begin
                            cnt_q    <= 5'd0;
                            acc_lo_q <= mag_a;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 5'd0;
                    end else if (cnt_q == 5'd31) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= fast_err_q;
                        result_q <= fast_q ? acc_lo_q : final_res;
                        cnt_q    <= 5'd0;
                    end else begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        cnt_q    <= cnt_q + 5'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign stall  = (state_q == S_IDLE && start && !flush) || (state_q == S_BUSY);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done, stall, err;
    logic [31:0] result;
    int          total = 0;
    int          bad = 0;

    mdu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
        .done(done), .result(result), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic pre_stall, output logic gap);
        @(negedge clk);
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1 pre_stall = stall;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        gap = 1'b0;
        while (!done && lat < 40) begin
            if (!stall) gap = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst_n = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start_busy: got %b want 1", busy); end
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1 lat++; end
        total++; if (lat !== 32) begin bad++; $display("FAIL first_start_latency: got %0d want 32", lat); end
        total++; if (result !== 32'd30) begin bad++; $display("FAIL first_start_result: got %h want 1e", result); end
    endtask

    task automatic test_mul();
        logic [2:0]  f[6];
        logic [31:0] a[6], b[6], e[6];
        int          lat;
        logic        ps, gap;
        f = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000, 3'b011};
        a = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0001, 32'h0001_0001};
        b = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h0001_0001, 32'h0001_0001};
        e = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h0002_0001, 32'h1};
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], a[i], b[i], lat, ps, gap);
            total++; if (lat !== 32) begin bad++; $display("FAIL mul%0d_latency: got %0d want 32", i, lat); end
            total++; if (result !== e[i]) begin bad++; $display("FAIL mul%0d_result: got %h want %h", i, result, e[i]); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL mul%0d_err: got %b want 0", i, err); end
            total++; if (!ps || gap) begin bad++; $display("FAIL mul%0d_stall_busy: pre=%b gap=%b want pre=1 gap=0", i, ps, gap); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL mul%0d_stall_done: got %b want 0", i, stall); end
        end
    endtask

    task automatic test_div();
        int          lat;
        logic        ps, gap;
`ifdef MDU_DIV_EN
        localparam int N = 10;
        logic [2:0]  f[N];
        logic [31:0] a[N], b[N], e[N];
        int          l[N];
        logic        ee;
        f = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111, 3'b110, 3'b100};
        a = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20, 32'h8000_0000, 32'h8000_0000,
              32'd100, 32'd100, 32'd7, 32'd7};
        b = '{32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        e = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd20, 32'h8000_0000, 32'd0,
              32'd14, 32'd2, 32'd1, 32'hFFFF_FFFD};
        l = '{32, 32, 1, 1, 1, 1, 32, 32, 32, 32};
        ee = 1'b0;
`else
        localparam int N = 3;
        logic [2:0]  f[N];
        logic [31:0] a[N], b[N], e[N];
        int          l[N];
        logic        ee;
        f = '{3'b100, 3'b111, 3'b101};
        a = '{32'd9, 32'd5, 32'd100};
        b = '{32'd3, 32'd0, 32'd7};
        e = '{32'd0, 32'd0, 32'd0};
        l = '{1, 1, 1};
        ee = 1'b1;
`endif
        for (int i = 0; i < N; i++) begin
            run_op(f[i], a[i], b[i], lat, ps, gap);
            total++; if (lat !== l[i]) begin bad++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, l[i]); end
            total++; if (result !== e[i]) begin bad++; $display("FAIL div%0d_result: got %h want %h", i, result, e[i]); end
            total++; if (err !== ee) begin bad++; $display("FAIL div%0d_err: got %b want %b", i, err, ee); end
        end
    endtask

    task automatic test_flush();
        int   lat;
        logic ps, gap, saw;
        run_op(3'b000, 32'd2, 32'd3, lat, ps, gap);
        total++; if (result !== 32'd6) begin bad++; $display("FAIL flush_prior_result: got %h want 6", result); end
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1 if (done) saw = 1'b1; end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0 || saw) begin bad++; $display("FAIL flush_done: got done=%b seen=%b want 0", done, saw); end
        total++; if (result !== 32'd6) begin bad++; $display("FAIL flush_result_held: got %h want 6", result); end
        run_op(3'b000, 32'd4, 32'd4, lat, ps, gap);
        total++; if (lat !== 32) begin bad++; $display("FAIL flush_restart_latency: got %0d want 32", lat); end
        total++; if (result !== 32'd16) begin bad++; $display("FAIL flush_restart_result: got %h want 10", result); end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic ps, gap, saw;
        @(negedge clk);
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
`ifdef MDU_DIV_EN
        funct3 = 3'b101;
`else
        funct3 = 3'b011;
`endif
        op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL midreset_result: got %h want 0", result); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL midreset_err: got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1 if (done || busy) saw = 1'b1; end
        total++; if (saw) begin bad++; $display("FAIL midreset_no_done: got activity=1 want 0"); end
        run_op(3'b000, 32'd3, 32'd5, lat, ps, gap);
        total++; if (result !== 32'd15 || lat !== 32) begin bad++; $display("FAIL midreset_after: got %h lat %0d want f lat 32", result, lat); end
    endtask

    task automatic test_flush_start_idle();
        logic saw;
        @(negedge clk);
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; start = 1'b1; flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_flush_stall: got %b want 0", stall); end
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_flush_busy: got %b want 0", busy); end
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1 if (done || busy) saw = 1'b1; end
        total++; if (saw) begin bad++; $display("FAIL idle_flush_activity: got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 op_a = 32'd10; op_b = 32'd10;
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1 lat++; end
        total++; if (lat !== 32 || result !== 32'd9) begin bad++; $display("FAIL b2b_first: got %h lat %0d want 9 lat 32", result, lat); end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_done_ignores_start: got busy=%b done=%b want 0 0", busy, done); end
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_start: got %b want 1", busy); end
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1 lat++; end
        total++; if (lat !== 32 || result !== 32'd100) begin bad++; $display("FAIL b2b_second: got %h lat %0d want 64 lat 32", result, lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_flush_start_idle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
